// File: rtl/tpu_host_bridge.sv
// tpu_host_bridge: host-side Avalon-MM front end for tpuv1.
// Pairs C-row halves into back-to-back tpu writes and stalls the host during MAC runs and reads.
module tpu_host_bridge #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADDRW-1:0] avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [DATAW-1:0] avs_writedata,
    output logic             avs_waitrequest,
    output logic [DATAW-1:0] avs_readdata,
    output logic             avs_readdatavalid,
    output logic             tpu_r_w,
    output logic [ADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0] tpu_dataIn,
    input  logic [DATAW-1:0] tpu_dataOut,
    output logic             mac_done,
    output logic             err
);
    localparam int MAC_CYCLES = 3*DIM-2;
    localparam int CW         = $clog2(MAC_CYCLES);
    localparam int CROW_BYTES = DIM*BITS_C/8;
    localparam logic [ADDRW-1:0] A_BASE    = ADDRW'(32'h0100);
    localparam logic [ADDRW-1:0] B_BASE    = ADDRW'(32'h0200);
    localparam logic [ADDRW-1:0] C_BASE    = ADDRW'(32'h0300);
    localparam logic [ADDRW-1:0] MAC_ADDR  = ADDRW'(32'h0400);
    localparam logic [ADDRW-1:0] STAT_ADDR = ADDRW'(32'h0500);
    localparam logic [ADDRW-1:0] AB_SPAN   = ADDRW'(DIM*DIM*BITS_AB/8);
    localparam logic [ADDRW-1:0] C_SPAN    = ADDRW'(DIM*CROW_BYTES);
    localparam logic [ADDRW-1:0] C_HALF    = ADDRW'(CROW_BYTES/2);

    typedef enum logic [2:0] {IDLE, C_HOLD, C_HI, MAC_BUSY, RD_CAP} state_t;

    function automatic logic in_rng(input logic [ADDRW-1:0] a, input logic [ADDRW-1:0] base,
                                    input logic [ADDRW-1:0] span);
        return (a >= base) && (a < base + span);
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             r_w_q, r_w_d;
    logic [ADDRW-1:0] addr_q, addr_d, buf_addr_q, buf_addr_d;
    logic [DATAW-1:0] din_q, din_d, buf_data_q, buf_data_d, rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d, done_q, done_d, err_q, err_d;
    logic [1:0]       stat_q, stat_d;
    logic             acc, pair, from_idle, err_set, err_clr, is_ab, is_c;

    assign avs_waitrequest   = (state_q == C_HI) || (state_q == MAC_BUSY) || (state_q == RD_CAP);
    assign acc               = (avs_read || avs_write) && !avs_waitrequest;
    assign pair              = (state_q == C_HOLD) && acc && avs_write && (avs_address == buf_addr_q + C_HALF);
    assign from_idle         = acc && !pair && ((state_q == IDLE) || (state_q == C_HOLD));
    assign is_ab             = in_rng(avs_address, A_BASE, AB_SPAN) || in_rng(avs_address, B_BASE, AB_SPAN);
    assign is_c              = in_rng(avs_address, C_BASE, C_SPAN);
    // Any non-pairing command in C_HOLD, an orphan high half, or read+write together is a protocol error.
    assign err_set           = (from_idle && (state_q == C_HOLD)) || (acc && avs_read && avs_write)
                             || (from_idle && avs_write && is_c && ((avs_address & C_HALF) != '0));
    assign err_clr           = from_idle && avs_write && (avs_address == STAT_ADDR);
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign tpu_r_w           = r_w_q;
    assign tpu_addr          = addr_q;
    assign tpu_dataIn        = din_q;
    assign mac_done          = done_q;
    assign err               = err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_w_d      = 1'b0;
        addr_d     = '0;
        din_d      = '0;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        done_d     = 1'b0;
        stat_d     = stat_q;
        err_d      = err_set || (err_q && !err_clr);
        if (pair || state_q == C_HI) begin
            r_w_d      = 1'b1;
            addr_d     = buf_addr_q;
            din_d      = buf_data_q;
            buf_addr_d = avs_address;
            buf_data_d = avs_writedata;
            state_d    = pair ? C_HI : IDLE;
        end
        if (from_idle) begin
            state_d = IDLE;
            if (avs_write) begin
                r_w_d      = is_ab || (avs_address == MAC_ADDR);
                addr_d     = r_w_d ? avs_address : '0;
                din_d      = is_ab ? avs_writedata : '0;
                state_d    = (avs_address == MAC_ADDR) ? MAC_BUSY :
                             (is_c && (avs_address & C_HALF) == '0) ? C_HOLD : IDLE;
                buf_addr_d = avs_address;
                buf_data_d = avs_writedata;
                cnt_d      = '0;
            end else begin
                addr_d  = avs_address;
                stat_d  = {err_set || err_q, state_q != IDLE};
                state_d = RD_CAP;
            end
        end
        if (state_q == MAC_BUSY) begin
            cnt_d   = cnt_q + CW'(1);
            done_d  = cnt_q == CW'(MAC_CYCLES-2);
            state_d = (cnt_q == CW'(MAC_CYCLES-1)) ? IDLE : MAC_BUSY;
        end
        if (state_q == RD_CAP) begin
            rdata_d  = in_rng(addr_q, C_BASE, C_SPAN) ? tpu_dataOut :
                       (addr_q == STAT_ADDR) ? {{(DATAW-2){1'b0}}, stat_q} : '0;
            rvalid_d = 1'b1;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            r_w_q      <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            done_q     <= 1'b0;
            stat_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_w_q      <= r_w_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            done_q     <= done_d;
            stat_q     <= stat_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_tpu_host_bridge.sv
// tb_tpu_host_bridge: directed self-checking bench for tpu_host_bridge.
module tb_tpu_host_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] avs_address = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0;
    logic [63:0] avs_writedata = '0;
    logic        avs_waitrequest;
    logic [63:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        tpu_r_w;
    logic [15:0] tpu_addr;
    logic [63:0] tpu_dataIn;
    logic [63:0] tpu_dataOut = '0;
    logic        mac_done, err;
    int          n_chk = 0, n_fail = 0;

    tpu_host_bridge dut (
        .clk(clk), .rst_n(rst_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest),
        .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid), .tpu_r_w(tpu_r_w),
        .tpu_addr(tpu_addr), .tpu_dataIn(tpu_dataIn), .tpu_dataOut(tpu_dataOut),
        .mac_done(mac_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [15:0] a, input logic [63:0] d);
        avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d;
        tick();
        avs_read = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0;
    endtask

    task automatic chk_bus(input string tag, input logic rw, input logic [15:0] a, input logic [63:0] d);
        chk({tag, "_rw"}, 64'(tpu_r_w), 64'(rw));
        chk({tag, "_addr"}, 64'(tpu_addr), 64'(a));
        chk({tag, "_din"}, tpu_dataIn, d);
    endtask

    initial begin
        int busy_cyc, done_at, bus_seen;
        tick(); tick();
        chk("rst_wait", 64'(avs_waitrequest), 0);
        chk_bus("rst_bus", 0, 16'h0, 64'h0);
        chk("rst_rv", 64'(avs_readdatavalid), 0);
        chk("rst_rd", avs_readdata, 0);
        chk("rst_done", 64'(mac_done), 0);
        chk("rst_err", 64'(err), 0);
        rst_n = 1'b1;
        tick();
        // reset in the middle of a MAC run
        req(0, 1, 16'h0400, 64'h0);
        chk_bus("mac1_issue", 1, 16'h0400, 64'h0);
        chk("mac1_wait", 64'(avs_waitrequest), 1);
        tick(); tick(); tick(); tick();
        chk("mac1_midwait", 64'(avs_waitrequest), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_wait", 64'(avs_waitrequest), 0);
        chk_bus("abort_bus", 0, 16'h0, 64'h0);
        chk("abort_done", 64'(mac_done), 0);
        tick();
        rst_n = 1'b1;
        // A write accepted on the first cycle after reset release
        req(0, 1, 16'h0100, 64'h0807060504030201);
        chk_bus("a_wr", 1, 16'h0100, 64'h0807060504030201);
        chk("a_wait", 64'(avs_waitrequest), 0);
        tick();
        chk_bus("a_idle", 0, 16'h0, 64'h0);
        // paired C row
        req(0, 1, 16'h0310, 64'h1111_2222_3333_4444);
        chk_bus("c_hold", 0, 16'h0, 64'h0);
        chk("c_hold_wait", 64'(avs_waitrequest), 0);
        req(0, 1, 16'h0318, 64'h5555_6666_7777_8888);
        chk_bus("c_lo", 1, 16'h0310, 64'h1111_2222_3333_4444);
        chk("c_hi_wait", 64'(avs_waitrequest), 1);
        tick();
        chk_bus("c_hi", 1, 16'h0318, 64'h5555_6666_7777_8888);
        chk("c_after_wait", 64'(avs_waitrequest), 0);
        tick();
        chk_bus("c_idle", 0, 16'h0, 64'h0);
        chk("c_err", 64'(err), 0);
        // full MAC run
        req(0, 1, 16'h0400, 64'h0);
        chk_bus("mac_issue", 1, 16'h0400, 64'h0);
        busy_cyc = avs_waitrequest ? 1 : 0;
        done_at = mac_done ? busy_cyc : 0;
        bus_seen = 0;
        for (int i = 0; i < 40 && avs_waitrequest; i++) begin
            tick();
            if (tpu_r_w) bus_seen = 1;
            if (avs_waitrequest) busy_cyc++;
            if (mac_done) done_at = busy_cyc;
        end
        chk("mac_wait_cycles", 64'(busy_cyc), 22);
        chk("mac_done_at", 64'(done_at), 22);
        chk("mac_bus_quiet", 64'(bus_seen), 0);
        chk("mac_done_after", 64'(mac_done), 0);
        // orphaned C low half followed by an A write
        req(0, 1, 16'h0300, 64'hDEAD_BEEF_0000_0001);
        req(0, 1, 16'h0108, 64'hA5A5_0000_0000_5A5A);
        chk_bus("orph_a", 1, 16'h0108, 64'hA5A5_0000_0000_5A5A);
        chk("orph_err", 64'(err), 1);
        tick();
        chk_bus("orph_idle", 0, 16'h0, 64'h0);
        req(1, 0, 16'h0500, 64'h0);
        chk_bus("stat_rd", 0, 16'h0500, 64'h0);
        chk("stat_wait", 64'(avs_waitrequest), 1);
        chk("stat_rv0", 64'(avs_readdatavalid), 0);
        tick();
        chk("stat_rv", 64'(avs_readdatavalid), 1);
        chk("stat_data", avs_readdata, 64'h2);
        tick();
        chk("stat_rv_pulse", 64'(avs_readdatavalid), 0);
        chk("stat_hold", avs_readdata, 64'h2);
        req(0, 1, 16'h0500, 64'h0);
        chk("err_clr", 64'(err), 0);
        // C read
        tpu_dataOut = 64'h1234;
        req(1, 0, 16'h0300, 64'h0);
        chk_bus("c_rd", 0, 16'h0300, 64'h0);
        tick();
        chk("c_rd_rv", 64'(avs_readdatavalid), 1);
        chk("c_rd_data", avs_readdata, 64'h1234);
        // unmapped read returns zero
        req(1, 0, 16'h0600, 64'h0);
        tick();
        chk("um_rd_data", avs_readdata, 64'h0);
        // orphan high half, unmapped write, read+write collision
        req(0, 1, 16'h0328, 64'h77);
        chk_bus("hi_orph_bus", 0, 16'h0, 64'h0);
        chk("hi_orph_err", 64'(err), 1);
        req(0, 1, 16'h0500, 64'h0);
        req(0, 1, 16'h0700, 64'h99);
        chk_bus("um_wr_bus", 0, 16'h0, 64'h0);
        chk("um_wr_err", 64'(err), 0);
        req(1, 1, 16'h0200, 64'hBB);
        chk_bus("rw_both", 1, 16'h0200, 64'hBB);
        chk("rw_both_err", 64'(err), 1);
        chk("rw_both_wait", 64'(avs_waitrequest), 0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
